// File: rtl/mgt_01_exec_commit_buffer_if.sv
// Execute-to-writeback bundle for the commit buffer: the execute beat, the writeback head
// and the fetch redirect.
interface mgt_01_exec_commit_buffer_if #(
    parameter int unsigned XLEN = 32
);
    // Execute stage side
    logic            valid_i;
    logic            ready_o;
    logic [XLEN-1:0] result_i;
    logic            comparison_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] offset_i;
    logic [4:0]      rd_i;
    logic [1:0]      kind_i;
    logic            flush_i;

    // Writeback side
    logic            valid_o;
    logic            ready_i;
    logic [XLEN-1:0] wb_data_o;
    logic [4:0]      wb_rd_o;
    logic            wb_en_o;

    // Fetch redirect
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;

    modport master (
        output valid_i, result_i, comparison_i, pc_i, offset_i, rd_i, kind_i, flush_i, ready_i,
        input  ready_o, valid_o, wb_data_o, wb_rd_o, wb_en_o, redirect_o, redirect_pc_o
    );

    modport slave (
        input  valid_i, result_i, comparison_i, pc_i, offset_i, rd_i, kind_i, flush_i, ready_i,
        output ready_o, valid_o, wb_data_o, wb_rd_o, wb_en_o, redirect_o, redirect_pc_o
    );
endinterface

// File: rtl/mgt_01_exec_commit_buffer.sv
// Execute-stage result buffer: queues writeback beats in a small FIFO and turns taken
// branches and jumps into a one-cycle fetch redirect pulse.
module mgt_01_exec_commit_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    mgt_01_exec_commit_buffer_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
    localparam logic [XLEN-1:0] LinkOff = XLEN'(4);

    localparam logic [1:0] KindAlu    = 2'b00;
    localparam logic [1:0] KindBranch = 2'b01;
    localparam logic [1:0] KindJump   = 2'b10;
    localparam logic [1:0] KindNop    = 2'b11;

    // Entry storage
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [DEPTH-1:0] en_q;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ready_q, ready_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    logic            push, pop, not_empty;
    logic [XLEN-1:0] entry_data;
    logic            entry_en;
    logic            taken;
    logic [XLEN-1:0] target;

    assign not_empty = (count_q != '0);

    // A beat arriving during a redirect or flush still handshakes but is dropped.
    assign push = bus.valid_i & ready_q & ~redirect_q & ~bus.flush_i;
    assign pop  = not_empty & bus.ready_i;

    always_comb begin
        entry_data = '0;
        entry_en   = 1'b0;
        taken      = 1'b0;
        target     = '0;
        unique case (bus.kind_i)
            KindAlu: begin
                entry_data = bus.result_i;
                entry_en   = (bus.rd_i != 5'd0);
            end
            KindBranch: begin
                taken  = bus.comparison_i;
                target = bus.pc_i + bus.offset_i;
            end
            KindJump: begin
                entry_data = bus.pc_i + LinkOff;
                entry_en   = (bus.rd_i != 5'd0);
                taken      = 1'b1;
                target     = {bus.result_i[XLEN-1:1], 1'b0};
            end
            KindNop: begin
                entry_data = '0;
            end
            default: begin
                entry_data = '0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntOne;
                2'b01:   count_d = count_q - CntOne;
                default: count_d = count_q;
            endcase
            if (push && taken) begin
                redirect_d    = 1'b1;
                redirect_pc_d = target;
            end
        end
        ready_d = (count_d != CntFull);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            ready_q       <= 1'b1;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            ready_q       <= ready_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
            end
            en_q <= '0;
        end else if (push) begin
            data_q[wr_ptr_q] <= entry_data;
            rd_q[wr_ptr_q]   <= bus.rd_i;
            en_q[wr_ptr_q]   <= entry_en;
        end
    end

    // Stale slots stay in storage after a pop, so the head is gated when empty.
    assign bus.ready_o       = ready_q;
    assign bus.valid_o       = not_empty;
    assign bus.wb_data_o     = not_empty ? data_q[rd_ptr_q] : '0;
    assign bus.wb_rd_o       = not_empty ? rd_q[rd_ptr_q] : 5'd0;
    assign bus.wb_en_o       = not_empty & en_q[rd_ptr_q];
    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
endmodule

// File: tb/tb_mgt_01_exec_commit_buffer.sv
// Self-checking bench for mgt_01_exec_commit_buffer: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_mgt_01_exec_commit_buffer;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        en;
    } entry_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    entry_t      mq[$];
    logic        m_redir;
    logic [31:0] m_rpc;

    mgt_01_exec_commit_buffer_if #(.XLEN(32)) bus ();

    mgt_01_exec_commit_buffer #(
        .DEPTH(DEPTH),
        .XLEN (32)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    task automatic drive_idle();
        bus.valid_i      = 1'b0;
        bus.result_i     = '0;
        bus.comparison_i = 1'b0;
        bus.pc_i         = '0;
        bus.offset_i     = '0;
        bus.rd_i         = '0;
        bus.kind_i       = 2'b11;
        bus.flush_i      = 1'b0;
    endtask

    task automatic drive_beat(input logic [1:0] kind, input logic [31:0] res, input logic cmp,
                              input logic [31:0] pc, input logic [31:0] off,
                              input logic [4:0] rd);
        bus.valid_i      = 1'b1;
        bus.kind_i       = kind;
        bus.result_i     = res;
        bus.comparison_i = cmp;
        bus.pc_i         = pc;
        bus.offset_i     = off;
        bus.rd_i         = rd;
        bus.flush_i      = 1'b0;
    endtask

    // Advance one clock and move the reference model forward by the same edge.
    task automatic tick();
        bit          do_pop, do_push, taken, fl;
        entry_t      e;
        logic [31:0] tgt;
        fl      = bus.flush_i;
        do_pop  = (mq.size() != 0) && bus.ready_i;
        do_push = bus.valid_i && (mq.size() != DEPTH) && !m_redir && !fl;
        e       = '0;
        e.rd    = bus.rd_i;
        taken   = 1'b0;
        tgt     = '0;
        case (bus.kind_i)
            2'b00: begin
                e.data = bus.result_i;
                e.en   = (bus.rd_i != 0);
            end
            2'b01: begin
                taken = bus.comparison_i;
                tgt   = bus.pc_i + bus.offset_i;
            end
            2'b10: begin
                e.data = bus.pc_i + 32'd4;
                e.en   = (bus.rd_i != 0);
                taken  = 1'b1;
                tgt    = bus.result_i & ~32'd1;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_redir = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
            m_redir = do_push && taken;
            if (m_redir) m_rpc = tgt;
        end
    endtask

    task automatic do_reset();
        drive_idle();
        bus.ready_i = 1'b1;
        rst_n       = 1'b0;
        mq.delete();
        m_redir = 1'b0;
        m_rpc   = '0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.ready_i = 1'b0;
        rst_n       = 1'b0;
        mq.delete();
        m_redir = 1'b0;
        m_rpc   = '0;
        #7;
        n_checks++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b, required 0", bus.valid_o);
        end
        n_checks++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, required 1", bus.ready_o);
        end
        n_checks++;
        if ({bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_wb: got data=%h rd=%0d en=%b, required all 0",
                     bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o);
        end
        n_checks++;
        if ({bus.redirect_o, bus.redirect_pc_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_redirect: got %b pc=%h, required 0 pc=0",
                     bus.redirect_o, bus.redirect_pc_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        do_reset();
        drive_beat(2'b00, 32'h11, 1'b0, 32'h40, 32'h0, 5'd5);
        tick();
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o} !== {1'b1, 32'h11, 5'd5, 1'b1})
        begin
            n_fail++;
            $display("FAIL alu_first: got v=%b d=%h rd=%0d en=%b, required v=1 d=11 rd=5 en=1",
                     bus.valid_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o);
        end
        drive_beat(2'b00, 32'h22, 1'b0, 32'h44, 32'h0, 5'd5);
        tick();
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o, bus.wb_en_o} !== {1'b1, 32'h22, 1'b1}) begin
            n_fail++;
            $display("FAIL alu_second: got v=%b d=%h en=%b, required v=1 d=22 en=1",
                     bus.valid_o, bus.wb_data_o, bus.wb_en_o);
        end
        drive_beat(2'b00, 32'h33, 1'b0, 32'h48, 32'h0, 5'd0);
        tick();
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o, bus.wb_en_o} !== {1'b1, 32'h33, 1'b0}) begin
            n_fail++;
            $display("FAIL alu_rd0: got v=%b d=%h en=%b, required v=1 d=33 en=0",
                     bus.valid_o, bus.wb_data_o, bus.wb_en_o);
        end
        drive_idle();
        tick();
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o} !== 33'd0) begin
            n_fail++;
            $display("FAIL alu_drained: got v=%b d=%h, required v=0 d=0",
                     bus.valid_o, bus.wb_data_o);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.ready_i = 1'b0;
        drive_beat(2'b00, 32'hA1, 1'b0, 32'h0, 32'h0, 5'd1);
        tick();
        drive_beat(2'b00, 32'hA2, 1'b0, 32'h0, 32'h0, 5'd2);
        tick();
        n_checks++;
        if (bus.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_full_ready: got %b, required 0", bus.ready_o);
        end
        drive_beat(2'b00, 32'hA3, 1'b0, 32'h0, 32'h0, 5'd3);
        tick();
        n_checks++;
        if ({bus.ready_o, bus.valid_o, bus.wb_data_o} !== {1'b0, 1'b1, 32'hA1}) begin
            n_fail++;
            $display("FAIL bp_hold: got rdy=%b v=%b d=%h, required rdy=0 v=1 d=a1",
                     bus.ready_o, bus.valid_o, bus.wb_data_o);
        end
        bus.ready_i = 1'b1;
        tick();
        n_checks++;
        if ({bus.ready_o, bus.wb_data_o} !== {1'b1, 32'hA2}) begin
            n_fail++;
            $display("FAIL bp_first_pop: got rdy=%b d=%h, required rdy=1 d=a2",
                     bus.ready_o, bus.wb_data_o);
        end
        tick();
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o, bus.wb_rd_o} !== {1'b1, 32'hA3, 5'd3}) begin
            n_fail++;
            $display("FAIL bp_third: got v=%b d=%h rd=%0d, required v=1 d=a3 rd=3",
                     bus.valid_o, bus.wb_data_o, bus.wb_rd_o);
        end
        drive_idle();
        tick();
        n_checks++;
        if (bus.valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%b, required 0", bus.valid_o);
        end
    endtask

    task automatic test_branch();
        do_reset();
        drive_beat(2'b01, 32'h0, 1'b1, 32'h100, 32'hFFFF_FFF0, 5'd3);
        tick();
        n_checks++;
        if ({bus.redirect_o, bus.redirect_pc_o} !== {1'b1, 32'h0F0}) begin
            n_fail++;
            $display("FAIL br_taken: got r=%b pc=%h, required r=1 pc=000000f0",
                     bus.redirect_o, bus.redirect_pc_o);
        end
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o, bus.wb_en_o} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL br_entry: got v=%b d=%h en=%b, required v=1 d=0 en=0",
                     bus.valid_o, bus.wb_data_o, bus.wb_en_o);
        end
        drive_beat(2'b00, 32'h55, 1'b0, 32'h104, 32'h0, 5'd7);
        tick();
        n_checks++;
        if ({bus.redirect_o, bus.redirect_pc_o, bus.valid_o} !== {1'b0, 32'h0F0, 1'b0}) begin
            n_fail++;
            $display("FAIL br_squash: got r=%b pc=%h v=%b, required r=0 pc=000000f0 v=0",
                     bus.redirect_o, bus.redirect_pc_o, bus.valid_o);
        end
        drive_beat(2'b01, 32'h0, 1'b0, 32'h300, 32'h40, 5'd0);
        tick();
        n_checks++;
        if ({bus.redirect_o, bus.redirect_pc_o, bus.valid_o} !== {1'b0, 32'h0F0, 1'b1}) begin
            n_fail++;
            $display("FAIL br_not_taken: got r=%b pc=%h v=%b, required r=0 pc=000000f0 v=1",
                     bus.redirect_o, bus.redirect_pc_o, bus.valid_o);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_jump();
        do_reset();
        drive_beat(2'b10, 32'h1235, 1'b0, 32'h200, 32'h0, 5'd1);
        tick();
        n_checks++;
        if ({bus.redirect_o, bus.redirect_pc_o} !== {1'b1, 32'h1234}) begin
            n_fail++;
            $display("FAIL jump_redirect: got r=%b pc=%h, required r=1 pc=00001234",
                     bus.redirect_o, bus.redirect_pc_o);
        end
        n_checks++;
        if ({bus.valid_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o} !== {1'b1, 32'h204, 5'd1, 1'b1})
        begin
            n_fail++;
            $display("FAIL jump_link: got v=%b d=%h rd=%0d en=%b, required v=1 d=204 rd=1 en=1",
                     bus.valid_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o);
        end
        drive_idle();
        tick();
        n_checks++;
        if ({bus.redirect_o, bus.valid_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL jump_pulse_end: got r=%b v=%b, required r=0 v=0",
                     bus.redirect_o, bus.valid_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        bus.ready_i = 1'b0;
        drive_beat(2'b00, 32'hB1, 1'b0, 32'h0, 32'h0, 5'd4);
        tick();
        drive_beat(2'b00, 32'hB2, 1'b0, 32'h0, 32'h0, 5'd4);
        tick();
        drive_beat(2'b01, 32'h0, 1'b1, 32'h500, 32'h20, 5'd0);
        bus.flush_i = 1'b1;
        bus.ready_i = 1'b1;
        tick();
        n_checks++;
        if ({bus.valid_o, bus.ready_o, bus.redirect_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush: got v=%b rdy=%b r=%b, required v=0 rdy=1 r=0",
                     bus.valid_o, bus.ready_o, bus.redirect_o);
        end
        n_checks++;
        if (bus.redirect_pc_o !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_pc_hold: got %h, required 00000000", bus.redirect_pc_o);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid_and_wrap();
        do_reset();
        bus.ready_i = 1'b0;
        drive_beat(2'b10, 32'h8001, 1'b0, 32'h700, 32'h0, 5'd9);
        tick();
        drive_idle();
        #2;
        rst_n = 1'b0;
        mq.delete();
        m_redir = 1'b0;
        m_rpc   = '0;
        #1;
        n_checks++;
        if ({bus.valid_o, bus.ready_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o,
             bus.redirect_o, bus.redirect_pc_o} !== {1'b0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0})
        begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b rdy=%b d=%h r=%b pc=%h, required 0 1 0 0 0",
                     bus.valid_o, bus.ready_o, bus.wb_data_o, bus.redirect_o,
                     bus.redirect_pc_o);
        end
        #1;
        rst_n       = 1'b1;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            drive_beat(2'b00, 32'hC00 + 32'(i), 1'b0, 32'h0, 32'h0, 5'(i + 1));
            tick();
            n_checks++;
            if ({bus.valid_o, bus.wb_data_o, bus.wb_rd_o} !== {1'b1, 32'hC00 + 32'(i), 5'(i + 1)})
            begin
                n_fail++;
                $display("FAIL wrap_%0d: got v=%b d=%h rd=%0d, required v=1 d=%h rd=%0d", i,
                         bus.valid_o, bus.wb_data_o, bus.wb_rd_o, 32'hC00 + 32'(i), i + 1);
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        entry_t h;
        bit     ev;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            bus.valid_i      = ($urandom_range(0, 9) < 7);
            bus.kind_i       = 2'($urandom_range(0, 3));
            bus.result_i     = $urandom;
            bus.comparison_i = 1'($urandom_range(0, 1));
            bus.pc_i         = $urandom;
            bus.offset_i     = $urandom;
            bus.rd_i         = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            bus.flush_i      = ($urandom_range(0, 19) == 0);
            bus.ready_i      = ($urandom_range(0, 9) < 6);
            tick();
            ev = (mq.size() != 0);
            h  = '0;
            if (ev) h = mq[0];
            n_checks++;
            if ({bus.valid_o, bus.ready_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o,
                 bus.redirect_o, bus.redirect_pc_o} !==
                {ev, 1'(mq.size() != DEPTH), h.data, h.rd, h.en, m_redir, m_rpc}) begin
                n_fail++;
                $display("FAIL random_c%0d: got v=%b rdy=%b d=%h rd=%0d en=%b r=%b pc=%h, required v=%b rdy=%b d=%h rd=%0d en=%b r=%b pc=%h",
                         c, bus.valid_o, bus.ready_o, bus.wb_data_o, bus.wb_rd_o, bus.wb_en_o,
                         bus.redirect_o, bus.redirect_pc_o, ev, mq.size() != DEPTH, h.data,
                         h.rd, h.en, m_redir, m_rpc);
            end
        end
        drive_idle();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        drive_idle();
        bus.ready_i = 1'b0;
        m_redir     = 1'b0;
        m_rpc       = '0;
        test_reset();
        test_alu();
        test_backpressure();
        test_branch();
        test_jump();
        test_flush();
        test_reset_mid_and_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mgt_01_exec_commit_buffer.md
# mgt_01_exec_commit_buffer

Execute-stage result buffer that sits directly downstream of the integer ALU. It captures each ALU result and comparison flag together with instruction metadata, and resolves branches and jumps into a one-cycle redirect pulse. Writeback beats are queued in a small FIFO toward the writeback stage under a valid/ready handshake. The FIFO back-pressures the execute stage when full and squashes wrong-path beats after a taken control transfer.

## Interface
Parameters:
- DEPTH, 2, number of FIFO entries; power of two, ≥ 2
- XLEN, 32, datapath width

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- valid_i  in  1  execute beat valid
- ready_o  out  1  buffer can accept; registered, equals (count != DEPTH)
- result_i  in  XLEN  ALU result
- comparison_i  in  1  ALU comparison flag
- pc_i  in  XLEN  PC of the instruction
- offset_i  in  XLEN  branch immediate (sign-extended)
- rd_i  in  5  destination register index
- kind_i  in  2  00 ALU, 01 BRANCH, 10 JUMP, 11 NOP
- flush_i  in  1  synchronous pipeline flush (trap/exception)
- valid_o  out  1  head entry valid toward writeback
- ready_i  in  1  writeback accepts head
- wb_data_o  out  XLEN  head writeback data
- wb_rd_o  out  5  head destination register
- wb_en_o  out  1  head register-write enable
- redirect_o  out  1  one-cycle fetch redirect pulse
- redirect_pc_o  out  XLEN  redirect target

## Operation
- Push condition: valid_i & ready_o & !redirect_o & !flush_i.
- A beat with valid_i & ready_o during redirect_o or flush_i completes its handshake and is discarded (squash).
- Pop condition: valid_o & ready_i.
- Entry contents by kind:
  - ALU: data = result_i, wb_en = (rd_i != 0).
  - BRANCH: data = 0, wb_en = 0.
  - JUMP: data = pc_i + 4 (link value), wb_en = (rd_i != 0).
  - NOP: data = 0, wb_en = 0.
- Every pushed kind occupies one entry and is popped normally.
- Redirect on a pushed BRANCH with comparison_i = 1:
  - redirect_pc_o = pc_i + offset_i.
  - redirect_o = 1 on the next cycle only.
- Redirect on a pushed JUMP:
  - redirect_pc_o = result_i & ~1 (the ALU computes the target).
  - redirect_o = 1 on the next cycle only.
- No redirect for a BRANCH with comparison_i = 0, or for ALU and NOP beats.
- redirect_pc_o holds its last value when redirect_o = 0.
- Arithmetic is XLEN-bit modulo 2^XLEN; no overflow detection.
- FIFO:
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push cannot occur when count = DEPTH.
- Outputs valid_o, wb_data_o, wb_rd_o and wb_en_o come from the head entry's storage.
  - valid_o = (count != 0).
  - wb_* are 0 when the buffer is empty.
- flush_i has priority over push, pop and redirect. On the next edge:
  - count = 0, pointers = 0.
  - Pending redirect is cancelled: redirect_o = 0.
  - Any pop in the flush cycle is still treated as consumed.
- Reset (asynchronous, effective immediately; pointers, count and storage reset):
  - valid_o = 0, ready_o = 1.
  - wb_data_o = 0, wb_rd_o = 0, wb_en_o = 0.
  - redirect_o = 0, redirect_pc_o = 0.
- Reset asserted mid-operation discards all entries and any pending redirect. The first edge after deassertion behaves as empty.

## Timing
- Push-to-valid_o latency: 1 cycle (entry visible the cycle after the accepting edge).
- Push-to-redirect_o latency: 1 cycle. Pulse width is exactly 1 cycle. Back-to-back redirects cannot occur because the beat after a redirect is squashed.
- Throughput: 1 beat/cycle with ready_i held high.
- ready_o is registered and has no combinational path from ready_i. A pop in cycle N frees space visible on ready_o in cycle N+1.
- ready_o and valid_o have no combinational path from valid_i.
- The head holds stable while valid_o & !ready_i.

## Test plan
- Reset, then push ALU beats result 0x11, 0x22 with rd=5, ready_i=1 -> valid_o on the next cycles with wb_data_o 0x11 then 0x22, wb_en_o=1, wb_rd_o=5; rd=0 beat -> wb_en_o=0.
- ready_i=0, push 3 beats (DEPTH=2) -> ready_o low after 2 pushes, third beat held by upstream. Raise ready_i -> beats drain in order, ready_o returns high one cycle after first pop.
- BRANCH pc=0x100, offset=0xFFFFFFF0, comparison=1, followed immediately by an ALU beat -> redirect_o pulse for 1 cycle, redirect_pc_o=0x0F0, following ALU beat squashed (never on valid_o); comparison=0 -> no pulse.
- JUMP pc=0x200, result_i=0x1235, rd=1 -> redirect_pc_o=0x1234, writeback entry wb_data_o=0x204, wb_en_o=1.
- Fill buffer, assert flush_i together with a taken BRANCH push -> next cycle valid_o=0, ready_o=1, redirect_o=0.
- Assert rst_n_i low mid-stream with 1 entry queued and redirect pending -> all outputs immediately at reset values; after release, first new push appears normally, pointer wrap verified over ≥ 3×DEPTH pushes.
